// File: rtl/seg_serial_tx_if.sv
// seg_serial_tx_if: frame request handshake between the segment-pattern mux and the serial transmitter
//   p_data/start : requester -> transmitter
//   busy/done    : transmitter -> requester
interface seg_serial_tx_if #(parameter int DATA_W = 64);
  logic [DATA_W-1:0] p_data;
  logic              start;
  logic              busy;
  logic              done;
  modport master (output p_data, start, input busy, done);
  modport slave  (input p_data, start, output busy, done);
endinterface

// File: rtl/seg_serial_tx.sv
// seg_serial_tx: parallel-to-serial transmitter feeding the external 7-segment shift-register chain
//   clk, rst (async, active-low) ; bus: p_data/start in, busy/done out
//   s_clk/sout : serial clock and data, chain samples on s_clk rising
//   s_clrn     : active-low chain clear ; en : display enable, low while loading
module seg_serial_tx #(
  parameter int DATA_W    = 64,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  seg_serial_tx_if.slave   bus,
  output logic             s_clk,
  output logic             s_clrn,
  output logic             sout,
  output logic             en
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, LATCH} state_t;
  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sr_q, sr_d, sr_nxt;
  logic              phase_q, phase_d;
  logic              s_clk_q, s_clk_d, s_clrn_q, s_clrn_d, sout_q, sout_d;
  logic              en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic              tick, cur_bit, nxt_bit;
  assign tick    = div_q == DIV_W'(CLK_DIV - 1);
  assign sr_nxt  = MSB_FIRST != 0 ? {sr_q[DATA_W-2:0], 1'b0} : {1'b0, sr_q[DATA_W-1:1]};
  assign cur_bit = MSB_FIRST != 0 ? sr_q[DATA_W-1] : sr_q[0];
  assign nxt_bit = MSB_FIRST != 0 ? sr_nxt[DATA_W-1] : sr_nxt[0];
  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : DIV_W'(div_q + 1'b1);
    bit_d    = bit_q;
    sr_d     = sr_q;
    phase_d  = phase_q;
    s_clk_d  = s_clk_q;
    s_clrn_d = s_clrn_q;
    sout_d   = sout_q;
    en_d     = en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.start) begin
          state_d  = CLEAR;
          sr_d     = bus.p_data;
          busy_d   = 1'b1;
          s_clrn_d = 1'b0;
          en_d     = 1'b0;
        end
      end
      CLEAR: if (tick) begin
        state_d  = SHIFT;
        bit_d    = '0;
        phase_d  = 1'b0;
        s_clrn_d = 1'b1;
        sout_d   = cur_bit;
      end
      SHIFT: if (tick) begin
        if (!phase_q) begin
          phase_d = 1'b1;
          s_clk_d = 1'b1;
        end else if (bit_q == BIT_W'(DATA_W - 1)) begin
          state_d = LATCH;
          s_clk_d = 1'b0;
          sout_d  = 1'b0;
          en_d    = 1'b1;
        end else begin
          bit_d   = BIT_W'(bit_q + 1'b1);
          sr_d    = sr_nxt;
          sout_d  = nxt_bit;
          s_clk_d = 1'b0;
          phase_d = 1'b0;
        end
      end
      default: if (tick) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      phase_q  <= 1'b0;
      s_clk_q  <= 1'b0;
      s_clrn_q <= 1'b1;
      sout_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      phase_q  <= phase_d;
      s_clk_q  <= s_clk_d;
      s_clrn_q <= s_clrn_d;
      sout_q   <= sout_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  assign s_clk    = s_clk_q;
  assign s_clrn   = s_clrn_q;
  assign sout     = sout_q;
  assign en       = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
